ram_dp_param: RTL and testbench

Parametrised dual-port synchronous RAM. It is the next-generation instruction/data memory for the simple CPU. Port A serves instruction fetch and port B serves data load/store, both with registered reads and 1-cycle latency. Port B writes take per-byte enables. A hardware clear sequencer fills the whole array with a fixed value after reset or on request, replacing hard-coded memory initialisation.

---
 rtl/ram_dp_param_if.sv | 31 +++
 rtl/ram_dp_param.sv | 111 +++++++++++
 tb/tb_ram_dp_param.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/ram_dp_param_if.sv
// Port bundle for ram_dp_param: clear control plus the port A fetch and port B load/store buses.
interface ram_dp_param_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
);
  localparam int NB = DATA_W / 8;

  logic              init_req;
  logic              busy;
  logic              a_en;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_rdata;
  logic              a_valid;
  logic              b_en;
  logic              b_we;
  logic [NB-1:0]     b_be;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic [DATA_W-1:0] b_rdata;
  logic              b_valid;

  modport master (
    output init_req, a_en, a_addr, b_en, b_we, b_be, b_addr, b_wdata,
    input  busy, a_rdata, a_valid, b_rdata, b_valid
  );

  modport slave (
    input  init_req, a_en, a_addr, b_en, b_we, b_be, b_addr, b_wdata,
    output busy, a_rdata, a_valid, b_rdata, b_valid
  );
endinterface

// File: rtl/ram_dp_param.sv
// Dual-port synchronous RAM with byte-enabled port B writes and a hardware clear sequencer.
// Optional macro RAM_FWD_EN: port A returns the merged word on an A-read/B-write same-address collision.
module ram_dp_param #(
  parameter int                DATA_W    = 16,
  parameter int                ADDR_W    = 8,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  ram_dp_param_if.slave   bus
);
  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] clr_cnt;
  logic              busy, clr_we, idle_req;
  logic              a_rd, b_rd, b_wr;
  logic [DATA_W-1:0] a_word;
  logic [DATA_W-1:0] mem [DEPTH];

  logic [DATA_W-1:0] a_rdata_p1, b_rdata_p1;
  logic              a_vld_p1, b_vld_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_CLEAR;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_CLEAR: if (clr_cnt == {ADDR_W{1'b1}}) state_nxt = ST_IDLE;
      ST_IDLE:  if (bus.init_req)              state_nxt = ST_CLEAR;
      default:                                 state_nxt = ST_CLEAR;
    endcase
  end

  // A request arriving together with init_req loses to the clear.
  always_comb begin
    busy     = (state == ST_CLEAR);
    clr_we   = busy && rst_n;
    idle_req = (state == ST_IDLE) && !bus.init_req;
    a_rd     = idle_req && bus.a_en;
    b_rd     = idle_req && bus.b_en && !bus.b_we;
    b_wr     = idle_req && bus.b_en && bus.b_we;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                clr_cnt <= '0;
    else if (state == ST_CLEAR) clr_cnt <= clr_cnt + 1'b1;
    else if (bus.init_req)     clr_cnt <= '0;
  end

  // Array storage carries no reset; only the clear sequencer initialises it.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_cnt] <= CLEAR_VAL;
    end else if (b_wr) begin
      for (int i = 0; i < NB; i++) begin
        if (bus.b_be[i]) mem[bus.b_addr][8*i +: 8] <= bus.b_wdata[8*i +: 8];
      end
    end
  end

`ifdef RAM_FWD_EN
  function automatic logic [DATA_W-1:0] merge_bytes(
    input logic [DATA_W-1:0] old_w,
    input logic [DATA_W-1:0] new_w,
    input logic [NB-1:0]     be
  );
    logic [DATA_W-1:0] res;
    res = old_w;
    for (int i = 0; i < NB; i++) begin
      if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

  always_comb begin
    a_word = mem[bus.a_addr];
    if (b_wr && (bus.a_addr == bus.b_addr))
      a_word = merge_bytes(mem[bus.a_addr], bus.b_wdata, bus.b_be);
  end
`else
  assign a_word = mem[bus.a_addr];
`endif

  // Stage p1: registered read data and valid pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_rdata_p1 <= '0;
      a_vld_p1   <= 1'b0;
      b_rdata_p1 <= '0;
      b_vld_p1   <= 1'b0;
    end else begin
      a_vld_p1 <= a_rd;
      b_vld_p1 <= b_rd;
      if (a_rd) a_rdata_p1 <= a_word;
      if (b_rd) b_rdata_p1 <= mem[bus.b_addr];
    end
  end

  assign bus.busy    = busy;
  assign bus.a_rdata = a_rdata_p1;
  assign bus.a_valid = a_vld_p1;
  assign bus.b_rdata = b_rdata_p1;
  assign bus.b_valid = b_vld_p1;
endmodule

// File: tb/tb_ram_dp_param.sv
// Directed bench for ram_dp_param: clear timing, byte enables, dual-port reads, collisions, re-init, reset mid-clear.
module tb_ram_dp_param;
  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;
  int   n_edges;
  logic blk_ok;

  ram_dp_param_if #(.DATA_W(16), .ADDR_W(8)) bus ();

  ram_dp_param #(.DATA_W(16), .ADDR_W(8), .CLEAR_VAL(16'h0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    bus.init_req = 1'b0;
    bus.a_en     = 1'b0;
    bus.b_en     = 1'b0;
    bus.b_we     = 1'b0;
    bus.b_be     = 2'b00;
  endtask

  task automatic b_write(input logic [7:0] addr, input logic [15:0] data, input logic [1:0] be);
    bus.b_en = 1'b1; bus.b_we = 1'b1; bus.b_be = be; bus.b_addr = addr; bus.b_wdata = data;
    step();
    quiet();
  endtask

  task automatic a_read(input string tag, input logic [7:0] addr, input logic [15:0] exp);
    bus.a_en = 1'b1; bus.a_addr = addr;
    step();
    quiet();
    chk({tag, "_data"}, {16'h0, bus.a_rdata}, {16'h0, exp});
    chk({tag, "_vld"}, {31'h0, bus.a_valid}, 32'd1);
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (bus.busy && n < 1000) begin
      step();
      n++;
    end
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    rst_n = 1'b0;
    quiet();
    bus.a_addr = '0; bus.b_addr = '0; bus.b_wdata = '0;
    repeat (3) step();

    chk("rst_busy",    {31'h0, bus.busy},    32'd1);
    chk("rst_a_valid", {31'h0, bus.a_valid}, 32'd0);
    chk("rst_b_valid", {31'h0, bus.b_valid}, 32'd0);
    chk("rst_a_rdata", {16'h0, bus.a_rdata}, 32'h0);
    chk("rst_b_rdata", {16'h0, bus.b_rdata}, 32'h0);

    rst_n = 1'b1;
    count_busy(n_edges);
    chk("clear_edges", n_edges, 256);

    a_read("clr00", 8'h00, 16'h0000);
    step();
    chk("clr00_pulse", {31'h0, bus.a_valid}, 32'd0);
    a_read("clr80", 8'h80, 16'h0000);
    a_read("clrFF", 8'hFF, 16'h0000);

    // Byte-enable writes
    b_write(8'h10, 16'hABCD, 2'b11);
    chk("wr1_bvld", {31'h0, bus.b_valid}, 32'd0);
    b_write(8'h10, 16'h1234, 2'b01);
    chk("wr2_bvld", {31'h0, bus.b_valid}, 32'd0);
    bus.b_en = 1'b1; bus.b_we = 1'b0; bus.b_addr = 8'h10;
    step();
    quiet();
    chk("be_rdata", {16'h0, bus.b_rdata}, 32'hAB34);
    chk("be_bvld",  {31'h0, bus.b_valid}, 32'd1);
    step();
    chk("be_bvld_drop", {31'h0, bus.b_valid}, 32'd0);
    chk("be_hold",      {16'h0, bus.b_rdata}, 32'hAB34);

    // Concurrent reads on both ports
    b_write(8'h01, 16'h1005, 2'b11);
    b_write(8'h02, 16'h20FF, 2'b11);
    bus.a_en = 1'b1; bus.a_addr = 8'h01;
    bus.b_en = 1'b1; bus.b_we = 1'b0; bus.b_addr = 8'h02;
    step();
    quiet();
    chk("dual_a",    {16'h0, bus.a_rdata}, 32'h1005);
    chk("dual_b",    {16'h0, bus.b_rdata}, 32'h20FF);
    chk("dual_avld", {31'h0, bus.a_valid}, 32'd1);
    chk("dual_bvld", {31'h0, bus.b_valid}, 32'd1);

    // Back-to-back port A reads, then both ports on one address
    a_read("b2b0", 8'h02, 16'h20FF);
    a_read("b2b1", 8'h10, 16'hAB34);
    bus.a_en = 1'b1; bus.a_addr = 8'h01;
    bus.b_en = 1'b1; bus.b_we = 1'b0; bus.b_addr = 8'h01;
    step();
    quiet();
    chk("same_a", {16'h0, bus.a_rdata}, 32'h1005);
    chk("same_b", {16'h0, bus.b_rdata}, 32'h1005);

    // Collision: A read and B write to 0x20
    b_write(8'h20, 16'h0000, 2'b11);
    bus.a_en = 1'b1; bus.a_addr = 8'h20;
    bus.b_en = 1'b1; bus.b_we = 1'b1; bus.b_be = 2'b10; bus.b_addr = 8'h20; bus.b_wdata = 16'hFFFF;
    step();
    quiet();
`ifdef RAM_FWD_EN
    chk("coll_a", {16'h0, bus.a_rdata}, 32'hFF00);
`else
    chk("coll_a", {16'h0, bus.a_rdata}, 32'h0000);
`endif
    chk("coll_bvld", {31'h0, bus.b_valid}, 32'd0);
    a_read("coll_after", 8'h20, 16'hFF00);

    // Re-init with requests blocked during busy
    b_write(8'h30, 16'h5555, 2'b11);
    a_read("pre_init", 8'h30, 16'h5555);
    bus.init_req = 1'b1; bus.a_en = 1'b1; bus.a_addr = 8'h30;
    step();
    bus.init_req = 1'b0;
    chk("init_busy", {31'h0, bus.busy},    32'd1);
    chk("init_avld", {31'h0, bus.a_valid}, 32'd0);
    bus.b_en = 1'b1; bus.b_we = 1'b1; bus.b_be = 2'b11; bus.b_addr = 8'h30; bus.b_wdata = 16'h1111;
    blk_ok = 1'b1;
    n_edges = 0;
    while (bus.busy && n_edges < 1000) begin
      step();
      n_edges++;
      if (bus.a_valid !== 1'b0 || bus.b_valid !== 1'b0) blk_ok = 1'b0;
    end
    quiet();
    chk("reinit_edges",  n_edges, 256);
    chk("reinit_blocked", {31'h0, blk_ok}, 32'd1);
    a_read("reinit30", 8'h30, 16'h0000);
    a_read("reinit10", 8'h10, 16'h0000);

    // Reset asserted partway through a clear
    b_write(8'hC8, 16'hBEEF, 2'b11);
    bus.a_en = 1'b1; bus.a_addr = 8'hC8;
    bus.b_en = 1'b1; bus.b_we = 1'b0; bus.b_addr = 8'hC8;
    step();
    quiet();
    chk("pre_rst_a", {16'h0, bus.a_rdata}, 32'hBEEF);
    chk("pre_rst_b", {16'h0, bus.b_rdata}, 32'hBEEF);
    bus.init_req = 1'b1;
    step();
    bus.init_req = 1'b0;
    repeat (100) step();
    chk("mid_busy", {31'h0, bus.busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_a_rdata", {16'h0, bus.a_rdata}, 32'h0);
    chk("mid_rst_b_rdata", {16'h0, bus.b_rdata}, 32'h0);
    chk("mid_rst_avld",    {31'h0, bus.a_valid}, 32'd0);
    chk("mid_rst_busy",    {31'h0, bus.busy},    32'd1);
    repeat (2) step();
    rst_n = 1'b1;
    count_busy(n_edges);
    chk("rst_clear_edges", n_edges, 256);
    a_read("rstC8", 8'hC8, 16'h0000);
    a_read("rst00", 8'h00, 16'h0000);
    a_read("rst20", 8'h20, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
